// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the bit-serial parity accumulator.
package serial_parity_pkg;

  // Controller states: collecting frame bits, or presenting a finished parity bit.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Default number of data bits per frame.
  localparam int unsigned FRAME_LEN_DEF = 8;

  // Width of the in-frame bit index for a frame of n bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/parity_xor_step.sv
// Single-bit XOR fold step (acc_next = acc ^ din) built only from NOR cells.
module parity_xor_step (
  input  logic acc,
  input  logic din,
  output logic acc_next
);

  logic n_ab;
  logic n_a;
  logic n_b;
  logic xnor_ab;

  // Four NORs form an XNOR; a fifth NOR wired as an inverter gives XOR.
  nor g_ab   (n_ab, acc, din);
  nor g_a    (n_a, acc, n_ab);
  nor g_b    (n_b, din, n_ab);
  nor g_xnor (xnor_ab, n_a, n_b);
  nor g_inv  (acc_next, xnor_ab, xnor_ab);

endmodule

// File: rtl/serial_parity_acc.sv
// Bit-serial parity accumulator: folds one bit per accepted beat and hands off
// one parity bit per FRAME_LEN-bit frame over a valid/ready interface.
// Define SERIAL_PARITY_ODD_EN for odd parity; otherwise even parity is produced.
module serial_parity_acc
  import serial_parity_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_bit,
  output logic                          in_ready,
  input  logic                          frame_clr,
  output logic                          out_valid,
  output logic                          out_parity,
  input  logic                          out_ready,
  output logic [idx_w(FRAME_LEN)-1:0]   bit_idx,
  output logic [CNT_W-1:0]              frame_cnt
);

  localparam int unsigned      IW       = idx_w(FRAME_LEN);
  localparam logic [IW-1:0]    LAST_IDX = IW'(FRAME_LEN - 1);
`ifdef SERIAL_PARITY_ODD_EN
  localparam logic             ODD      = 1'b1;
`else
  localparam logic             ODD      = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              acc_q, acc_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_parity_q, out_parity_d;
  logic              acc_step;

  parity_xor_step u_step (
    .acc      (acc_q),
    .din      (in_bit),
    .acc_next (acc_step)
  );

  // State register and datapath flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ACC;
      acc_q        <= 1'b0;
      bit_idx_q    <= '0;
      frame_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bit_idx_q    <= bit_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
    end
  end

  // Next-state logic: accumulate in ACC (abort wins over a beat), hand off in HOLD.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    bit_idx_d    = bit_idx_q;
    frame_cnt_d  = frame_cnt_q;
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    unique case (state_q)
      ST_ACC: begin
        if (frame_clr) begin
          acc_d     = 1'b0;
          bit_idx_d = '0;
        end else if (in_valid) begin
          if (bit_idx_q == LAST_IDX) begin
            out_parity_d = acc_step ^ ODD;
            out_valid_d  = 1'b1;
            acc_d        = 1'b0;
            bit_idx_d    = '0;
            state_d      = ST_HOLD;
          end else begin
            acc_d     = acc_step;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = ST_ACC;
        end
      end
    endcase
  end

  // Outputs come straight from registered state; in_ready never depends on out_ready.
  always_comb begin
    in_ready   = (state_q == ST_ACC);
    out_valid  = out_valid_q;
    out_parity = out_parity_q;
    bit_idx    = bit_idx_q;
    frame_cnt  = frame_cnt_q;
  end

endmodule

// File: tb/tb_serial_parity_acc.sv
// Testbench for serial_parity_acc: directed scenarios plus randomized traffic,
// checked every cycle against a frame-level reference model.
module tb_serial_parity_acc;

  localparam int unsigned FL = 8;
`ifdef SERIAL_PARITY_ODD_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_bit, frame_clr, out_ready;
  logic       in_ready_a, out_valid_a, out_parity_a;
  logic       in_ready_b, out_valid_b, out_parity_b;
  logic [2:0] bit_idx_a, bit_idx_b;
  logic [7:0] frame_cnt_a;
  logic [1:0] frame_cnt_b;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state: bits collected so far, pending parity, frames handed off.
  bit          m_hold;
  bit          m_bits[$];
  bit          m_par;
  int unsigned m_frames;

  always #5 clk = ~clk;

  serial_parity_acc #(.FRAME_LEN(FL), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_a), .frame_clr(frame_clr), .out_valid(out_valid_a),
    .out_parity(out_parity_a), .out_ready(out_ready), .bit_idx(bit_idx_a),
    .frame_cnt(frame_cnt_a)
  );

  serial_parity_acc #(.FRAME_LEN(FL), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_b), .frame_clr(frame_clr), .out_valid(out_valid_b),
    .out_parity(out_parity_b), .out_ready(out_ready), .bit_idx(bit_idx_b),
    .frame_cnt(frame_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    if (!rst_n) begin
      m_hold = 1'b0;
      m_bits.delete();
      m_par = 1'b0;
      m_frames = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        m_frames++;
      end
    end else if (frame_clr) begin
      m_bits.delete();
    end else if (in_valid) begin
      m_bits.push_back(in_bit);
      if (m_bits.size() == FL) begin
        m_par = ODD;
        foreach (m_bits[i]) m_par ^= m_bits[i];
        m_bits.delete();
        m_hold = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready_a"},   in_ready_a,   !m_hold);
    check({tag, ".in_ready_b"},   in_ready_b,   !m_hold);
    check({tag, ".out_valid"},    out_valid_a,  m_hold);
    check({tag, ".out_parity"},   out_parity_a, m_par);
    check({tag, ".out_parity_b"}, out_parity_b, m_par);
    check({tag, ".bit_idx"},      bit_idx_a,    m_bits.size());
    check({tag, ".frame_cnt8"},   frame_cnt_a,  m_frames % 256);
    check({tag, ".frame_cnt2"},   frame_cnt_b,  m_frames % 4);
  endtask

  task automatic cycle(input bit v, input bit b, input bit clr, input bit ordy, input string tag);
    in_valid  = v;
    in_bit    = b;
    frame_clr = clr;
    out_ready = ordy;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n = 1'b0;
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, "rst");
    rst_n = 1'b1;
  endtask

  initial begin : main
    logic [7:0]  pat;
    int unsigned pulses;
    bit          prev_v;
    int unsigned wrap_exp[5];

    wrap_exp = '{1, 2, 3, 0, 1};
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; frame_clr = 1'b0; out_ready = 1'b0;

    // 1: reset then idle
    do_reset(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    check("t1.in_ready", in_ready_a, 1'b1);
    check("t1.out_valid", out_valid_a, 1'b0);
    check("t1.out_parity", out_parity_a, 1'b0);
    check("t1.bit_idx", bit_idx_a, 0);
    check("t1.frame_cnt", frame_cnt_a, 0);

    // 2: back-to-back frame 1,0,1,1,0,0,1,0 with out_ready high
    pat = 8'b10110010;
    for (int i = 7; i >= 0; i--) cycle(1'b1, pat[i], 1'b0, 1'b1, "t2");
    check("t2.out_valid", out_valid_a, 1'b1);
    check("t2.parity", out_parity_a, 1'(ODD));
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "t2h");
    check("t2.frame_cnt", frame_cnt_a, 1);
    check("t2.in_ready", in_ready_a, 1'b1);

    // 3: backpressure on 1,1,1,0,0,0,0,0
    pat = 8'b11100000;
    for (int i = 7; i >= 0; i--) cycle(1'b1, pat[i], 1'b0, 1'b0, "t3");
    for (int unsigned k = 0; k < 5; k++) begin
      cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0, "t3w");
      check("t3.parity_held", out_parity_a, 1'(1'b1 ^ ODD));
      check("t3.in_ready_low", in_ready_a, 1'b0);
      check("t3.cnt_held", frame_cnt_a, 1);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "t3r");
    check("t3.frame_cnt", frame_cnt_a, 2);

    // 4: abort after 5 bits, abort beat carries a bit that must be dropped
    for (int unsigned k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 1'b1, "t4p");
    cycle(1'b1, 1'b1, 1'b1, 1'b1, "t4c");
    check("t4.bit_idx", bit_idx_a, 0);
    pat = 8'b01000000;
    for (int i = 7; i >= 0; i--) cycle(1'b1, pat[i], 1'b0, 1'b0, "t4f");
    check("t4.parity", out_parity_a, 1'(1'b1 ^ ODD));
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "t4h");

    // 5: counter wrap on the 2-bit instance
    do_reset(1);
    for (int unsigned f = 0; f < 5; f++) begin
      for (int unsigned k = 0; k < FL; k++) cycle(1'b1, 1'($urandom), 1'b0, 1'b1, "t5");
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "t5h");
      check("t5.wrap", frame_cnt_b, wrap_exp[f]);
    end

    // 6: reset mid-frame, then one fresh frame
    for (int unsigned k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b1, "t6p");
    do_reset(1);
    pulses = 0;
    prev_v = 1'b0;
    pat = 8'b00000111;
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b1, pat[i], 1'b0, 1'b0, "t6f");
      if (out_valid_a && !prev_v) pulses++;
      prev_v = out_valid_a;
    end
    check("t6.parity", out_parity_a, 1'(1'b1 ^ ODD));
    for (int unsigned k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "t6h");
      if (out_valid_a && !prev_v) pulses++;
      prev_v = out_valid_a;
    end
    check("t6.pulses", pulses, 1);

    // Randomized traffic with occasional abort and reset
    for (int unsigned k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
